tff_bank_ctrl: RTL and testbench
================================

// Module: tff_bank_ctrl
// PURPOSE
//   Shared-access controller for a bank of W toggle flip-flops, each with a T input and a Q output.
//   NREQ requesters each ask for "bit IDX := VAL". The block arbitrates round-robin.
//   It compares the requested value against the bank's Q and pulses the bit's T only on a mismatch.
//   It then verifies the toggle and acknowledges. This turns a toggle-only bank into a settable,
//   shared register resource.
// PARAMETERS
//   NREQ  4  number of requesters (2..8)
//   W     8  number of TFFs in the bank
//   IW    3  index width per requester, clog2(W)
// PORTS
//   CLK      in   1        system clock; all state updates on posedge
//   RST      in   1        reset: asynchronous assert, active-high
//   REQ      in   NREQ     per-requester request; hold high until own ACK
//   REQ_IDX  in   NREQ*IW  target bit index; slice [i*IW +: IW] belongs to requester i
//   REQ_VAL  in   NREQ     requested bit value per requester
//   ACK      out  NREQ     one-cycle completion pulse, one-hot
//   ERR      out  1        one-cycle pulse coincident with ACK: request failed
//   BUSY     out  1        high in every state except IDLE
//   T_OUT    out  W        one-hot toggle enable to the bank's T inputs
//   Q_IN     in   W        bank Q outputs; bank toggles on the same CLK edge
// BEHAVIOUR
//   Reset state:
//     - state=IDLE, rr_ptr=0; ACK, ERR, BUSY and T_OUT all 0.
//     - The bank itself has no reset; its Q is not cleared.
//   Registered outputs: all outputs are registered. T_OUT is never combinational.
//   IDLE:
//     - Only state that samples REQ.
//     - Winner = first requester with REQ high, searching rr_ptr, rr_ptr+1, ... mod NREQ.
//     - Latch id, idx and val of the winner.
//     - idx >= W  -> DONE with err=1; no toggle.
//     - Q_IN[idx]==val  -> DONE; no toggle.
//     - Otherwise T_OUT <= 1<<idx, go to TOGGLE.
//   TOGGLE (1 cycle): T_OUT is high; the bank flips on the edge ending this cycle.
//     T_OUT <= 0, go to VERIFY.
//   VERIFY (1 cycle): Q_IN[idx]!=val -> err=1. Go to DONE.
//   DONE (1 cycle):
//     - ACK[id]=1, ERR=err.
//     - rr_ptr <= (id+1) mod NREQ.
//     - Go to IDLE.
//   Latency from the IDLE cycle that sees REQ to the ACK cycle:
//     - 3 cycles when a toggle is needed.
//     - 1 cycle when no toggle is needed or the index is bad.
//   Requester rules:
//     - Drop REQ in the cycle after ACK; IDLE resamples REQ immediately.
//     - REQ dropped mid-operation: the operation still completes and ACK is still issued.
//     - REQ_IDX and REQ_VAL are only sampled in IDLE; later changes are ignored.
//   Arbitration:
//     - At most one operation is in flight and at most one T_OUT bit is high.
//     - Simultaneous requests are served in rr order, so no requester starves.
//   RST mid-operation:
//     - Immediate return to IDLE with all outputs 0.
//     - Pending ACK is lost; requesters must re-request.
//     - RST during TOGGLE may leave the bank toggled. This is allowed.
// TESTING
//   1) Reset with Q_IN=8'h00; REQ0 idx=3 val=1.
//      -> T_OUT=8'h08 for 1 cycle; ACK=4'b0001 3 cycles after grant; ERR=0; Q_IN=8'h08.
//   2) Q_IN=8'h08; REQ1 idx=3 val=1.
//      -> no T_OUT activity; ACK=4'b0010 next cycle; ERR=0.
//   3) REQ=4'b1111 held, rr_ptr=0, each requester drops REQ after its ACK.
//      -> ACK order 0001, 0010, 0100, 1000.
//   4) Bank model stuck (ignores T); REQ2 idx=5 val=1 with Q_IN[5]=0.
//      -> T_OUT=8'h20 pulse; ACK=4'b0100 with ERR=1.
//   5) W=6 IW=3 build; REQ3 idx=7.
//      -> T_OUT stays 0; ACK=4'b1000 with ERR=1 next cycle.
//   6) Assert RST during TOGGLE.
//      -> T_OUT, ACK and BUSY go 0 asynchronously; state=IDLE; rr_ptr=0; no ACK after release.

Source files
------------

// File: rtl/tff_bank_ctrl.sv
// Round-robin shared-access controller that turns a toggle-only TFF bank into a
// settable register: pulse T only when the requested value differs from Q, then verify.
//
// state  | meaning
// IDLE   | sample requests, arbitrate, decide toggle / no-toggle / bad index
// TOGGLE | T_OUT pulse is high; bank flips on the edge ending this cycle
// VERIFY | check that Q now matches the requested value
// DONE   | ACK/ERR pulse to the winner, advance round-robin pointer
module tff_bank_ctrl #(
    parameter int NREQ = 4,
    parameter int W    = 8,
    parameter int IW   = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req,
    input  logic [NREQ*IW-1:0]   req_idx,
    input  logic [NREQ-1:0]      req_val,
    output logic [NREQ-1:0]      ack,
    output logic                 err,
    output logic                 busy,
    output logic [W-1:0]         t_out,
    input  logic [W-1:0]         q_in
);

    localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        TOGGLE = 2'd1,
        VERIFY = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t            state, state_d;
    logic [IDW-1:0]    rr_ptr, rr_ptr_d;
    logic [IDW-1:0]    id, id_d;
    logic [IW-1:0]     idx, idx_d;
    logic              val, val_d;
    logic [NREQ-1:0]   ack_d;
    logic              err_d;
    logic              busy_d;
    logic [W-1:0]      t_out_d;

    logic              found;
    logic [IDW-1:0]    w_id;
    logic [IW-1:0]     w_idx;
    logic              w_val;
    logic              w_bad;
    int                cand;

    // Round-robin search starting at rr_ptr.
    always_comb begin
        found = 1'b0;
        w_id  = '0;
        w_idx = '0;
        w_val = 1'b0;
        cand  = 0;
        for (int k = 0; k < NREQ; k++) begin
            cand = (int'(rr_ptr) + k) % NREQ;
            if (!found && req[cand]) begin
                found = 1'b1;
                w_id  = IDW'(cand);
                w_idx = req_idx[cand*IW +: IW];
                w_val = req_val[cand];
            end
        end
        w_bad = (int'(w_idx) >= W);
    end

    always_comb begin
        state_d  = state;
        rr_ptr_d = rr_ptr;
        id_d     = id;
        idx_d    = idx;
        val_d    = val;
        ack_d    = '0;
        err_d    = 1'b0;
        t_out_d  = '0;
        case (state)
            IDLE: begin
                if (found) begin
                    id_d  = w_id;
                    idx_d = w_idx;
                    val_d = w_val;
                    if (w_bad) begin
                        state_d     = DONE;
                        ack_d[w_id] = 1'b1;
                        err_d       = 1'b1;
                    end else if (q_in[w_idx] == w_val) begin
                        state_d     = DONE;
                        ack_d[w_id] = 1'b1;
                    end else begin
                        state_d        = TOGGLE;
                        t_out_d[w_idx] = 1'b1;
                    end
                end
            end
            TOGGLE: begin
                state_d = VERIFY;
            end
            VERIFY: begin
                state_d   = DONE;
                ack_d[id] = 1'b1;
                err_d     = (q_in[idx] != val);
            end
            DONE: begin
                state_d  = IDLE;
                rr_ptr_d = (id == IDW'(NREQ - 1)) ? '0 : id + 1'b1;
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    // ACK/ERR/T_OUT are computed one state early so every output is a flop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            rr_ptr <= '0;
            id     <= '0;
            idx    <= '0;
            val    <= 1'b0;
            ack    <= '0;
            err    <= 1'b0;
            busy   <= 1'b0;
            t_out  <= '0;
        end else begin
            state  <= state_d;
            rr_ptr <= rr_ptr_d;
            id     <= id_d;
            idx    <= idx_d;
            val    <= val_d;
            ack    <= ack_d;
            err    <= err_d;
            busy   <= busy_d;
            t_out  <= t_out_d;
        end
    end

endmodule

// File: tb/tb_tff_bank_ctrl.sv
// Self-checking bench for tff_bank_ctrl: directed scenarios plus randomized traffic
// checked against a transaction-level model of arbitration and the TFF bank.
module tb_tff_bank_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic [3:0]  req_a, val_a, ack_a;
    logic [11:0] idx_a;
    logic        err_a, busy_a;
    logic [7:0]  t_a, q_a;
    logic [3:0]  req_b, val_b, ack_b;
    logic [11:0] idx_b;
    logic        err_b, busy_b;
    logic [5:0]  t_b, q_b;

    logic        stuck, ld_a, ld_b;
    logic [7:0]  ld_val_a;
    logic [5:0]  ld_val_b;

    int n_checks = 0;
    int n_fail   = 0;

    tff_bank_ctrl #(.NREQ(4), .W(8), .IW(3)) dut_a (
        .clk(clk), .rst(rst), .req(req_a), .req_idx(idx_a), .req_val(val_a),
        .ack(ack_a), .err(err_a), .busy(busy_a), .t_out(t_a), .q_in(q_a)
    );

    tff_bank_ctrl #(.NREQ(4), .W(6), .IW(3)) dut_b (
        .clk(clk), .rst(rst), .req(req_b), .req_idx(idx_b), .req_val(val_b),
        .ack(ack_b), .err(err_b), .busy(busy_b), .t_out(t_b), .q_in(q_b)
    );

    // TFF bank models: no reset, loadable by the bench, optionally stuck.
    always @(posedge clk) begin
        if (ld_a) q_a <= ld_val_a;
        else if (!stuck) q_a <= q_a ^ t_a;
    end
    always @(posedge clk) begin
        if (ld_b) q_b <= ld_val_b;
        else q_b <= q_b ^ t_b;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        req_a = '0;
        req_b = '0;
        tick();
        tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic set_bank_a(input logic [7:0] v);
        ld_val_a = v;
        ld_a = 1'b1;
        tick();
        ld_a = 1'b0;
    endtask

    task automatic set_bank_b(input logic [5:0] v);
        ld_val_b = v;
        ld_b = 1'b1;
        tick();
        ld_b = 1'b0;
    endtask

    function automatic int winner(input logic [3:0] m, input int rr);
        for (int k = 0; k < 4; k++)
            if (m[(rr + k) % 4]) return (rr + k) % 4;
        return -1;
    endfunction

    // Runs one operation starting in an IDLE cycle; returns observations only.
    task automatic do_op(input bit use_b, output int lat, output logic [3:0] ack_seen,
                         output logic err_seen, output logic [7:0] t_seen,
                         output int t_cnt, output bit busy_ok);
        logic [7:0] ct;
        logic [3:0] ca;
        logic       ce, cb;
        lat = -1; ack_seen = '0; err_seen = 1'b0; t_seen = '0; t_cnt = 0; busy_ok = 1'b1;
        for (int c = 1; c <= 10 && lat < 0; c++) begin
            tick();
            ct = use_b ? {2'b00, t_b} : t_a;
            ca = use_b ? ack_b : ack_a;
            ce = use_b ? err_b : err_a;
            cb = use_b ? busy_b : busy_a;
            if (ct != 0) t_cnt++;
            t_seen |= ct;
            if (!cb) busy_ok = 1'b0;
            if (ca != 0) begin
                lat = c;
                ack_seen = ca;
                err_seen = ce;
                if (use_b) req_b &= ~ca;
                else req_a &= ~ca;
            end
        end
        tick();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #3;
        n_checks++; if (ack_a !== 4'b0) begin n_fail++; $display("FAIL reset_ack_a got %b want 0000", ack_a); end
        n_checks++; if (err_a !== 1'b0) begin n_fail++; $display("FAIL reset_err_a got %b want 0", err_a); end
        n_checks++; if (busy_a !== 1'b0) begin n_fail++; $display("FAIL reset_busy_a got %b want 0", busy_a); end
        n_checks++; if (t_a !== 8'h00) begin n_fail++; $display("FAIL reset_t_a got %h want 00", t_a); end
        n_checks++; if ({ack_b, err_b, busy_b, t_b} !== 12'h0) begin n_fail++; $display("FAIL reset_b got %h want 000", {ack_b, err_b, busy_b, t_b}); end
        tick();
        rst = 1'b0;
        tick();
        tick();
        n_checks++; if ({ack_a, err_a, busy_a, t_a} !== 14'h0) begin n_fail++; $display("FAIL idle_after_reset got %h want 0000", {ack_a, err_a, busy_a, t_a}); end
    endtask

    task automatic test_toggle();
        int lat, tc; logic [3:0] a; logic e; logic [7:0] ts; bit bo;
        apply_reset();
        set_bank_a(8'h00);
        idx_a[2:0] = 3'd3; val_a[0] = 1'b1; req_a = 4'b0001;
        do_op(1'b0, lat, a, e, ts, tc, bo);
        n_checks++; if (lat !== 3) begin n_fail++; $display("FAIL toggle_latency got %0d want 3", lat); end
        n_checks++; if (a !== 4'b0001) begin n_fail++; $display("FAIL toggle_ack got %b want 0001", a); end
        n_checks++; if (e !== 1'b0) begin n_fail++; $display("FAIL toggle_err got %b want 0", e); end
        n_checks++; if (ts !== 8'h08 || tc !== 1) begin n_fail++; $display("FAIL toggle_t_out got %h x%0d want 08 x1", ts, tc); end
        n_checks++; if (!bo) begin n_fail++; $display("FAIL toggle_busy got low want high during op"); end
        n_checks++; if (q_a !== 8'h08) begin n_fail++; $display("FAIL toggle_bank got %h want 08", q_a); end
        n_checks++; if (busy_a !== 1'b0) begin n_fail++; $display("FAIL toggle_busy_idle got %b want 0", busy_a); end
    endtask

    task automatic test_no_toggle();
        int lat, tc; logic [3:0] a; logic e; logic [7:0] ts; bit bo;
        idx_a[5:3] = 3'd3; val_a[1] = 1'b1; req_a = 4'b0010;
        do_op(1'b0, lat, a, e, ts, tc, bo);
        n_checks++; if (lat !== 1) begin n_fail++; $display("FAIL match_latency got %0d want 1", lat); end
        n_checks++; if (a !== 4'b0010 || e !== 1'b0) begin n_fail++; $display("FAIL match_ack got %b/%b want 0010/0", a, e); end
        n_checks++; if (tc !== 0) begin n_fail++; $display("FAIL match_t_out got %0d pulses want 0", tc); end
        n_checks++; if (q_a !== 8'h08) begin n_fail++; $display("FAIL match_bank got %h want 08", q_a); end
    endtask

    task automatic test_round_robin();
        int lat, tc, rr, w; logic [3:0] a; logic e; logic [7:0] ts; bit bo;
        apply_reset();
        for (int i = 0; i < 4; i++) begin
            idx_a[i*3 +: 3] = 3'($urandom_range(0, 7));
            val_a[i] = 1'($urandom_range(0, 1));
        end
        req_a = 4'b1111;
        rr = 0;
        for (int k = 0; k < 4; k++) begin
            w = winner(req_a, rr);
            do_op(1'b0, lat, a, e, ts, tc, bo);
            n_checks++; if (a !== (4'b0001 << k) || w != k) begin n_fail++; $display("FAIL rr_order step %0d got %b want %b", k, a, 4'b0001 << k); end
            rr = (w + 1) % 4;
        end
    endtask

    task automatic test_stuck();
        int lat, tc; logic [3:0] a; logic e; logic [7:0] ts; bit bo;
        apply_reset();
        set_bank_a(8'h00);
        stuck = 1'b1;
        idx_a[8:6] = 3'd5; val_a[2] = 1'b1; req_a = 4'b0100;
        do_op(1'b0, lat, a, e, ts, tc, bo);
        n_checks++; if (ts !== 8'h20 || tc !== 1) begin n_fail++; $display("FAIL stuck_t_out got %h x%0d want 20 x1", ts, tc); end
        n_checks++; if (a !== 4'b0100 || lat !== 3) begin n_fail++; $display("FAIL stuck_ack got %b@%0d want 0100@3", a, lat); end
        n_checks++; if (e !== 1'b1) begin n_fail++; $display("FAIL stuck_err got %b want 1", e); end
        stuck = 1'b0;
    endtask

    task automatic test_bad_index();
        int lat, tc; logic [3:0] a; logic e; logic [7:0] ts; bit bo;
        apply_reset();
        set_bank_b(6'h00);
        idx_b[11:9] = 3'd7; val_b[3] = 1'b1; req_b = 4'b1000;
        do_op(1'b1, lat, a, e, ts, tc, bo);
        n_checks++; if (a !== 4'b1000 || e !== 1'b1 || lat !== 1) begin n_fail++; $display("FAIL bad_idx7 got %b/%b@%0d want 1000/1@1", a, e, lat); end
        n_checks++; if (tc !== 0) begin n_fail++; $display("FAIL bad_idx7_t_out got %0d pulses want 0", tc); end
        idx_b[2:0] = 3'd6; val_b[0] = 1'b0; req_b = 4'b0001;
        do_op(1'b1, lat, a, e, ts, tc, bo);
        n_checks++; if (a !== 4'b0001 || e !== 1'b1 || lat !== 1 || tc !== 0) begin n_fail++; $display("FAIL bad_idx6 got %b/%b@%0d t%0d want 0001/1@1 t0", a, e, lat, tc); end
        idx_b[5:3] = 3'd5; val_b[1] = 1'b1; req_b = 4'b0010;
        do_op(1'b1, lat, a, e, ts, tc, bo);
        n_checks++; if (a !== 4'b0010 || e !== 1'b0 || lat !== 3 || ts !== 8'h20) begin n_fail++; $display("FAIL top_idx5 got %b/%b@%0d t%h want 0010/0@3 t20", a, e, lat, ts); end
        n_checks++; if (q_b !== 6'h20) begin n_fail++; $display("FAIL top_idx5_bank got %h want 20", q_b); end
    endtask

    task automatic test_reset_mid();
        int lat, tc; logic [3:0] a, acc; logic e; logic [7:0] ts; bit bo;
        apply_reset();
        set_bank_a(8'h00);
        idx_a[5:3] = 3'd2; val_a[1] = 1'b0; req_a = 4'b0010;
        do_op(1'b0, lat, a, e, ts, tc, bo);
        idx_a[8:6] = 3'd4; val_a[2] = 1'b1; req_a = 4'b0100;
        tick();
        n_checks++; if (t_a !== 8'h10) begin n_fail++; $display("FAIL mid_toggle_t_out got %h want 10", t_a); end
        #2 rst = 1'b1;
        #1;
        n_checks++; if (t_a !== 8'h00) begin n_fail++; $display("FAIL mid_rst_t_out got %h want 00", t_a); end
        n_checks++; if (ack_a !== 4'b0 || busy_a !== 1'b0) begin n_fail++; $display("FAIL mid_rst_ack_busy got %b/%b want 0000/0", ack_a, busy_a); end
        req_a = '0;
        tick();
        tick();
        rst = 1'b0;
        acc = '0;
        for (int c = 0; c < 5; c++) begin
            tick();
            acc |= ack_a;
        end
        n_checks++; if (acc !== 4'b0) begin n_fail++; $display("FAIL mid_rst_lost_ack got %b want 0000", acc); end
        req_a = 4'b1111;
        do_op(1'b0, lat, a, e, ts, tc, bo);
        n_checks++; if (a !== 4'b0001) begin n_fail++; $display("FAIL mid_rst_rr_ptr got %b want 0001", a); end
        req_a = '0;
        tick();
        tick();
        tick();
    endtask

    task automatic test_random();
        int lat, tc, rr, w, i, exp_lat; logic [3:0] a; logic e; logic [7:0] ts, exp_bank, exp_t; bit bo, mism, exp_err;
        apply_reset();
        exp_bank = 8'($urandom);
        set_bank_a(exp_bank);
        rr = 0;
        for (int n = 0; n < 40; n++) begin
            for (int r = 0; r < 4; r++) begin
                if (!req_a[r] && $urandom_range(0, 1) == 1) begin
                    req_a[r] = 1'b1;
                    idx_a[r*3 +: 3] = 3'($urandom_range(0, 7));
                    val_a[r] = 1'($urandom_range(0, 1));
                end
            end
            if (req_a == 4'b0) begin
                w = $urandom_range(0, 3);
                req_a[w] = 1'b1;
                idx_a[w*3 +: 3] = 3'($urandom_range(0, 7));
                val_a[w] = 1'($urandom_range(0, 1));
            end
            stuck = ($urandom_range(0, 7) == 0);
            w = winner(req_a, rr);
            i = int'(idx_a[w*3 +: 3]);
            mism = (exp_bank[i] != val_a[w]);
            exp_lat = mism ? 3 : 1;
            exp_t = mism ? (8'h01 << i) : 8'h00;
            exp_err = mism && stuck;
            if (mism && !stuck) exp_bank[i] = ~exp_bank[i];
            rr = (w + 1) % 4;
            do_op(1'b0, lat, a, e, ts, tc, bo);
            n_checks++; if (a !== (4'b0001 << w)) begin n_fail++; $display("FAIL rand_ack op %0d got %b want %b", n, a, 4'b0001 << w); end
            n_checks++; if (e !== exp_err) begin n_fail++; $display("FAIL rand_err op %0d got %b want %b", n, e, exp_err); end
            n_checks++; if (lat !== exp_lat) begin n_fail++; $display("FAIL rand_latency op %0d got %0d want %0d", n, lat, exp_lat); end
            n_checks++; if (ts !== exp_t) begin n_fail++; $display("FAIL rand_t_out op %0d got %h want %h", n, ts, exp_t); end
        end
        stuck = 1'b0;
        n_checks++; if (q_a !== exp_bank) begin n_fail++; $display("FAIL rand_bank got %h want %h", q_a, exp_bank); end
    endtask

    initial begin
        rst = 1'b1;
        req_a = '0; idx_a = '0; val_a = '0;
        req_b = '0; idx_b = '0; val_b = '0;
        stuck = 1'b0; ld_a = 1'b0; ld_b = 1'b0;
        ld_val_a = '0; ld_val_b = '0;
        test_reset();
        test_toggle();
        test_no_toggle();
        test_round_robin();
        test_stuck();
        test_bad_index();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
